// File: rtl/sim_dump_window.sv
// rtl/sim_dump_window.sv - frame-based dump-window controller with CH independent window channels
module sim_dump_window #(
    parameter int CH = 2,
    parameter int FW = 32,
    parameter int LW = 16,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          led,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [1:0]    cfg_mode,
    input  logic [FW-1:0] cfg_start,
    input  logic [LW-1:0] cfg_len,
    output logic [FW-1:0] frame_cnt,
    output logic [CH-1:0] dump_en,
    output logic          dump_any,
    output logic          dump_on_p,
    output logic          dump_off_p
);

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_FRAME  = 2'd1;
    localparam logic [1:0] M_LED    = 2'd2;
    localparam logic [1:0] M_REPEAT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_GAP} state_t;

    state_t        state_q  [CH];
    state_t        state_d  [CH];
    logic [1:0]    mode_q   [CH];
    logic [1:0]    mode_d   [CH];
    logic [FW-1:0] start_q  [CH];
    logic [FW-1:0] start_d  [CH];
    logic [LW-1:0] len_q    [CH];
    logic [LW-1:0] len_d    [CH];
    logic [LW-1:0] remain_q [CH];
    logic [LW-1:0] remain_d [CH];
    logic [CH-1:0] pending_q, pending_d;

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          vs_last_q, led_last_q;
    logic [CH-1:0] dump_en_q, dump_en_d;
    logic          dump_any_q, dump_any_d, any_prev_q, on_q, off_q;
    logic          tick, led_rise;

    assign tick        = vs_last_q & ~vs;
    assign led_rise    = led & ~led_last_q;
    assign frame_cnt_d = frame_cnt_q + {{(FW-1){1'b0}}, tick};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]  <= S_IDLE;
                mode_q[i]   <= M_OFF;
                start_q[i]  <= '0;
                len_q[i]    <= '0;
                remain_q[i] <= '0;
            end
            pending_q   <= '0;
            frame_cnt_q <= '0;
            vs_last_q   <= 1'b1;
            led_last_q  <= 1'b0;
            dump_en_q   <= '0;
            dump_any_q  <= 1'b0;
            any_prev_q  <= 1'b0;
            on_q        <= 1'b0;
            off_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            vs_last_q   <= vs;
            led_last_q  <= led;
            dump_en_q   <= dump_en_d;
            dump_any_q  <= dump_any_d;
            any_prev_q  <= dump_any_q;
            on_q        <= dump_any_q & ~any_prev_q;
            off_q       <= ~dump_any_q & any_prev_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        start_d   = start_q;
        len_d     = len_q;
        remain_d  = remain_q;
        pending_d = pending_q;
        for (int i = 0; i < CH; i++) begin
            if (cfg_we && (cfg_ch == CW'(i))) begin
                mode_d[i]    = cfg_mode;
                start_d[i]   = cfg_start;
                len_d[i]     = cfg_len;
                pending_d[i] = 1'b0;
                state_d[i]   = (cfg_mode != M_OFF) ? S_ARMED : S_IDLE;
            end else begin
                if (tick) begin
                    case (state_q[i])
                        S_ARMED: begin
                            if (((mode_q[i] == M_FRAME) || (mode_q[i] == M_REPEAT))
                                    && (frame_cnt_q == start_q[i])) begin
                                state_d[i]  = S_ACTIVE;
                                remain_d[i] = len_q[i];
                            end else if ((mode_q[i] == M_LED) && pending_q[i]
                                    && (frame_cnt_q >= start_q[i])) begin
                                state_d[i]   = S_ACTIVE;
                                remain_d[i]  = len_q[i];
                                pending_d[i] = 1'b0;
                            end
                        end
                        S_ACTIVE: begin
                            // LED windows re-arm on close so a later trigger can reopen them
                            if (remain_q[i] == LW'(1)) begin
                                case (mode_q[i])
                                    M_REPEAT: begin
                                        state_d[i]  = S_GAP;
                                        remain_d[i] = len_q[i];
                                    end
                                    M_LED:   state_d[i] = S_ARMED;
                                    default: state_d[i] = S_IDLE;
                                endcase
                            end else if (remain_q[i] != '0) begin
                                remain_d[i] = remain_q[i] - LW'(1);
                            end
                        end
                        S_GAP: begin
                            if (remain_q[i] == LW'(1)) begin
                                state_d[i]  = S_ACTIVE;
                                remain_d[i] = len_q[i];
                            end else if (remain_q[i] != '0) begin
                                remain_d[i] = remain_q[i] - LW'(1);
                            end
                        end
                        default: state_d[i] = state_q[i];
                    endcase
                end
                if (led_rise && (mode_q[i] == M_LED)) begin
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        dump_en_d = '0;
        for (int i = 0; i < CH; i++) begin
            dump_en_d[i] = (state_d[i] == S_ACTIVE);
        end
        dump_any_d = |dump_en_d;
    end

    assign frame_cnt  = frame_cnt_q;
    assign dump_en    = dump_en_q;
    assign dump_any   = dump_any_q;
    assign dump_on_p  = on_q;
    assign dump_off_p = off_q;

endmodule
